// File: rtl/ctrl_seq.sv
// Control sequencer for the 4-bit-opcode accumulator CPU.
// Walks each instruction through fetch (F1/F2), decode (DEC) and execute (EX).
// Drives the datapath strobes and runs the memory request/ack handshake.
// A memory access that waits longer than TIMEOUT cycles halts the CPU with BUS_ERR.
module ctrl_seq #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RUN,
  input  logic       LDA,
  input  logic       STA,
  input  logic       ADD,
  input  logic       SUB,
  input  logic       XOR,
  input  logic       INC,
  input  logic       CLR,
  input  logic       JMP,
  input  logic       JPZ,
  input  logic       JPN,
  input  logic       HLT,
  input  logic       ZF,
  input  logic       NF,
  input  logic       MEM_ACK,
  output logic       MAR_LD,
  output logic       MAR_SEL_PC,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic       IR_LD,
  output logic       PC_INC,
  output logic       PC_LD,
  output logic       ACC_LD,
  output logic [2:0] ALU_OP,
  output logic       ILL_OP,
  output logic       HALTED,
  output logic       BUS_ERR,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F1   = 3'd1,
    S_F2   = 3'd2,
    S_DEC  = 3'd3,
    S_EX   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  // Single selected operation after priority resolution of the decode lines.
  typedef enum logic [3:0] {
    OP_NONE, OP_HLT, OP_JMP, OP_JPZ, OP_JPN, OP_STA,
    OP_LDA, OP_ADD, OP_SUB, OP_XOR, OP_INC, OP_CLR
  } op_t;

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        bus_err_q, bus_err_d;
  op_t         op;
  logic        ill;
  logic [10:0] dec_lines;

  assign dec_lines = {HLT, JMP, JPZ, JPN, STA, LDA, ADD, SUB, XOR, INC, CLR};
  assign ill       = ($countones(dec_lines) != 1);

  // Priority encoder: HLT > JMP > JPZ > JPN > STA > LDA > ADD > SUB > XOR > INC > CLR.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    op = OP_NONE;
    if      (HLT) op = OP_HLT;
    else if (JMP) op = OP_JMP;
    else if (JPZ) op = OP_JPZ;
    else if (JPN) op = OP_JPN;
    else if (STA) op = OP_STA;
    else if (LDA) op = OP_LDA;
    else if (ADD) op = OP_ADD;
    else if (SUB) op = OP_SUB;
    else if (XOR) op = OP_XOR;
    else if (INC) op = OP_INC;
    else if (CLR) op = OP_CLR;
  end

  // Next-state, wait counter, error flag and all datapath strobes.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    bus_err_d  = bus_err_q;
    MAR_LD     = 1'b0;
    MAR_SEL_PC = 1'b0;
    MEM_RD     = 1'b0;
    MEM_WR     = 1'b0;
    IR_LD      = 1'b0;
    PC_INC     = 1'b0;
    PC_LD      = 1'b0;
    ACC_LD     = 1'b0;
    ALU_OP     = 3'b000;
    ILL_OP     = 1'b0;
    HALTED     = 1'b0;

    case (state_q)
      S_IDLE: if (RUN) state_d = S_F1;

      S_F1: begin
        MAR_SEL_PC = 1'b1;
        MAR_LD     = 1'b1;
        wait_d     = 8'd0;
        state_d    = S_F2;
      end

      S_F2: begin
        MEM_RD = 1'b1;
        if (MEM_ACK) begin
          IR_LD   = 1'b1;
          PC_INC  = 1'b1;
          wait_d  = 8'd0;
          state_d = S_DEC;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == TIMEOUT_C) begin
            bus_err_d = 1'b1;
            state_d   = S_HALT;
          end
        end
      end

      S_DEC: begin
        ILL_OP  = ill;
        state_d = S_F1;
        case (op)
          OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_XOR: begin
            MAR_LD  = 1'b1;
            wait_d  = 8'd0;
            state_d = S_EX;
          end
          OP_INC: begin ACC_LD = 1'b1; ALU_OP = 3'b100; end
          OP_CLR: begin ACC_LD = 1'b1; ALU_OP = 3'b101; end
          OP_JMP: PC_LD = 1'b1;
          OP_JPZ: PC_LD = ZF;
          OP_JPN: PC_LD = NF;
          OP_HLT: state_d = S_HALT;
          default: ;
        endcase
      end

      S_EX: begin
        if (op == OP_STA) MEM_WR = 1'b1;
        else              MEM_RD = 1'b1;
        if (MEM_ACK) begin
          wait_d  = 8'd0;
          state_d = S_F1;
          case (op)
            OP_LDA: begin ACC_LD = 1'b1; ALU_OP = 3'b000; end
            OP_ADD: begin ACC_LD = 1'b1; ALU_OP = 3'b001; end
            OP_SUB: begin ACC_LD = 1'b1; ALU_OP = 3'b010; end
            OP_XOR: begin ACC_LD = 1'b1; ALU_OP = 3'b011; end
            default: ;
          endcase
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == TIMEOUT_C) begin
            bus_err_d = 1'b1;
            state_d   = S_HALT;
          end
        end
      end

      S_HALT: HALTED = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

  // State, wait counter and sticky error flag with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RST_N) begin
      state_q   <= S_IDLE;
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign BUS_ERR = bus_err_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed testbench for ctrl_seq: fetch/decode/execute sequencing,
// handshake timing, illegal opcodes, halt and bus timeout.
module tb_ctrl_seq;

  logic       CLK, RST_N, RUN;
  logic       LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT;
  logic       ZF, NF, MEM_ACK;
  logic       MAR_LD, MAR_SEL_PC, MEM_RD, MEM_WR, IR_LD, PC_INC, PC_LD, ACC_LD;
  logic [2:0] ALU_OP;
  logic       ILL_OP, HALTED, BUS_ERR;
  logic [2:0] STATE;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  ctrl_seq #(.TIMEOUT(15)) dut (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN),
    .LDA(LDA), .STA(STA), .ADD(ADD), .SUB(SUB), .XOR(XOR), .INC(INC),
    .CLR(CLR), .JMP(JMP), .JPZ(JPZ), .JPN(JPN), .HLT(HLT),
    .ZF(ZF), .NF(NF), .MEM_ACK(MEM_ACK),
    .MAR_LD(MAR_LD), .MAR_SEL_PC(MAR_SEL_PC), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
    .IR_LD(IR_LD), .PC_INC(PC_INC), .PC_LD(PC_LD), .ACC_LD(ACC_LD),
    .ALU_OP(ALU_OP), .ILL_OP(ILL_OP), .HALTED(HALTED), .BUS_ERR(BUS_ERR),
    .STATE(STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observed output vector, MSB first.
  logic [13:0] obs;
  assign obs = {MAR_LD, MAR_SEL_PC, MEM_RD, MEM_WR, IR_LD, PC_INC, PC_LD, ACC_LD,
                ALU_OP, ILL_OP, HALTED, BUS_ERR};

  localparam logic [13:0] M_MARLD = 14'h2000;
  localparam logic [13:0] M_SELPC = 14'h1000;
  localparam logic [13:0] M_RD    = 14'h0800;
  localparam logic [13:0] M_WR    = 14'h0400;
  localparam logic [13:0] M_IRLD  = 14'h0200;
  localparam logic [13:0] M_PCINC = 14'h0100;
  localparam logic [13:0] M_PCLD  = 14'h0080;
  localparam logic [13:0] M_ACCLD = 14'h0040;
  localparam logic [13:0] M_ILL   = 14'h0004;
  localparam logic [13:0] M_HALT  = 14'h0002;
  localparam logic [13:0] M_BERR  = 14'h0001;
  localparam logic [13:0] M_ALU_ADD = 14'h0008; // ALU_OP 001
  localparam logic [13:0] M_ALU_INC = 14'h0020; // ALU_OP 100
  localparam logic [13:0] M_ALU_CLR = 14'h0028; // ALU_OP 101

  // Decode line order: {HLT,JMP,JPZ,JPN,STA,LDA,ADD,SUB,XOR,INC,CLR}
  localparam logic [10:0] D_NONE = 11'b000_0000_0000;
  localparam logic [10:0] D_HLT  = 11'b100_0000_0000;
  localparam logic [10:0] D_JMP  = 11'b010_0000_0000;
  localparam logic [10:0] D_JPZ  = 11'b001_0000_0000;
  localparam logic [10:0] D_JPN  = 11'b000_1000_0000;
  localparam logic [10:0] D_STA  = 11'b000_0100_0000;
  localparam logic [10:0] D_LDA  = 11'b000_0010_0000;
  localparam logic [10:0] D_ADD  = 11'b000_0001_0000;
  localparam logic [10:0] D_INC  = 11'b000_0000_0010;
  localparam logic [10:0] D_CLR  = 11'b000_0000_0001;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_F1 = 3'd1, ST_F2 = 3'd2,
                         ST_DEC = 3'd3, ST_EX = 3'd4, ST_HALT = 3'd5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Check state and outputs for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [13:0] vec);
    #1;
    check({tag, ".state"}, {29'd0, STATE}, {29'd0, st});
    check({tag, ".outs"},  {18'd0, obs},   {18'd0, vec});
    tick();
  endtask

  task automatic set_dec(input logic [10:0] d);
    {HLT, JMP, JPZ, JPN, STA, LDA, ADD, SUB, XOR, INC, CLR} = d;
  endtask

  // F1 then F2 with an immediate ack; leaves the DUT in DEC.
  task automatic fetch(input string tag);
    cyc({tag, ".f1"}, ST_F1, M_MARLD | M_SELPC);
    MEM_ACK = 1'b1;
    cyc({tag, ".f2"}, ST_F2, M_RD | M_IRLD | M_PCINC);
    MEM_ACK = 1'b0;
  endtask

  task automatic reset_and_run();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    RUN   = 1'b1;
    cyc("run", ST_IDLE, 14'd0);
    RUN   = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; RUN = 1'b0; ZF = 1'b0; NF = 1'b0; MEM_ACK = 1'b0;
    set_dec(D_NONE);
    tick();
    tick();
    RST_N = 1'b1;
    cyc("reset", ST_IDLE, 14'd0);

    // Start and LDA with two wait cycles in both F2 and EX.
    RUN = 1'b1;
    cyc("idle_run", ST_IDLE, 14'd0);
    RUN = 1'b0;
    set_dec(D_LDA);
    cyc("lda.f1", ST_F1, M_MARLD | M_SELPC);
    cyc("lda.f2w1", ST_F2, M_RD);
    cyc("lda.f2w2", ST_F2, M_RD);
    MEM_ACK = 1'b1;
    cyc("lda.f2ack", ST_F2, M_RD | M_IRLD | M_PCINC);
    MEM_ACK = 1'b0;
    cyc("lda.dec", ST_DEC, M_MARLD);
    cyc("lda.exw1", ST_EX, M_RD);
    cyc("lda.exw2", ST_EX, M_RD);
    MEM_ACK = 1'b1;
    cyc("lda.exack", ST_EX, M_RD | M_ACCLD);
    MEM_ACK = 1'b0;

    // STA with immediate acks; the next fetch checks the return to F1.
    set_dec(D_STA);
    fetch("sta");
    cyc("sta.dec", ST_DEC, M_MARLD);
    MEM_ACK = 1'b1;
    cyc("sta.ex", ST_EX, M_WR);
    MEM_ACK = 1'b0;

    // Conditional and unconditional jumps.
    set_dec(D_JPZ); ZF = 1'b0;
    fetch("jpz0");
    cyc("jpz0.dec", ST_DEC, 14'd0);
    ZF = 1'b1;
    fetch("jpz1");
    cyc("jpz1.dec", ST_DEC, M_PCLD);
    ZF = 1'b0;
    set_dec(D_JPN); NF = 1'b1;
    fetch("jpn1");
    cyc("jpn1.dec", ST_DEC, M_PCLD);
    NF = 1'b0;
    set_dec(D_JMP);
    fetch("jmp");
    cyc("jmp.dec", ST_DEC, M_PCLD);

    // Single-cycle ALU ops.
    set_dec(D_INC);
    fetch("inc");
    cyc("inc.dec", ST_DEC, M_ACCLD | M_ALU_INC);
    set_dec(D_CLR);
    fetch("clr");
    cyc("clr.dec", ST_DEC, M_ACCLD | M_ALU_CLR);

    // ADD interrupted by reset in EX; an ack in IDLE must be ignored.
    set_dec(D_ADD);
    fetch("add");
    cyc("add.dec", ST_DEC, M_MARLD);
    cyc("add.ex", ST_EX, M_RD);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1; MEM_ACK = 1'b1;
    cyc("add.rst", ST_IDLE, 14'd0);
    MEM_ACK = 1'b0;
    cyc("idle.hold", ST_IDLE, 14'd0);

    // Illegal opcodes: none asserted, then two lines (STA wins over ADD).
    RUN = 1'b1;
    cyc("run2", ST_IDLE, 14'd0);
    RUN = 1'b0;
    set_dec(D_NONE);
    fetch("ill0");
    cyc("ill0.dec", ST_DEC, M_ILL);
    set_dec(D_STA | D_ADD);
    fetch("ill2");
    cyc("ill2.dec", ST_DEC, M_ILL | M_MARLD);
    MEM_ACK = 1'b1;
    cyc("ill2.ex", ST_EX, M_WR);
    MEM_ACK = 1'b0;

    // LDA+HLT: HLT wins, HALT entered, RUN ignored.
    set_dec(D_LDA | D_HLT);
    fetch("hlt");
    cyc("hlt.dec", ST_DEC, M_ILL);
    cyc("hlt.halt", ST_HALT, M_HALT);
    RUN = 1'b1;
    cyc("hlt.run", ST_HALT, M_HALT);
    RUN = 1'b0;
    cyc("hlt.stay", ST_HALT, M_HALT);

    // F2 timeout: 16 unacknowledged request cycles then BUS_ERR + HALT.
    reset_and_run();
    set_dec(D_LDA);
    cyc("to.f1", ST_F1, M_MARLD | M_SELPC);
    for (int i = 1; i <= 16; i++) cyc($sformatf("to.f2w%0d", i), ST_F2, M_RD);
    cyc("to.halt", ST_HALT, M_HALT | M_BERR);
    RUN = 1'b1;
    cyc("to.run", ST_HALT, M_HALT | M_BERR);
    RUN = 1'b0;

    // Ack on the 16th request cycle completes normally.
    reset_and_run();
    cyc("ack16.f1", ST_F1, M_MARLD | M_SELPC);
    for (int i = 1; i <= 15; i++) cyc($sformatf("ack16.f2w%0d", i), ST_F2, M_RD);
    MEM_ACK = 1'b1;
    cyc("ack16.f2ack", ST_F2, M_RD | M_IRLD | M_PCINC);
    MEM_ACK = 1'b0;
    cyc("ack16.dec", ST_DEC, M_MARLD);

    // EX timeout on the same LDA; ADD path checked for ALU_OP 001 first.
    for (int i = 1; i <= 16; i++) cyc($sformatf("exto.w%0d", i), ST_EX, M_RD);
    cyc("exto.halt", ST_HALT, M_HALT | M_BERR);

    reset_and_run();
    set_dec(D_ADD);
    fetch("add2");
    cyc("add2.dec", ST_DEC, M_MARLD);
    MEM_ACK = 1'b1;
    cyc("add2.ex", ST_EX, M_RD | M_ACCLD | M_ALU_ADD);
    MEM_ACK = 1'b0;
    cyc("add2.f1", ST_F1, M_MARLD | M_SELPC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
